// File: rtl/exc_pkg.sv
// Shared types and constants for the commit-side exception sequencer.
// Covers FSM states, event kinds, ExcCode values and the exception vector.
package exc_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    INT,
    EXC,
    ERET
  } kind_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] ADEL    = 5'd4;
  localparam logic [4:0] ADES    = 5'd5;
  localparam logic [4:0] SYS     = 5'd8;
  localparam logic [4:0] BP      = 5'd9;
  localparam logic [4:0] RI      = 5'd10;
  localparam logic [4:0] OV      = 5'd12;

endpackage

// File: rtl/exc_priority.sv
// Combinational event select at commit.
// Priority order is interrupt, then synchronous exception, then ERET.
module exc_priority
  import exc_pkg::*;
(
  input  logic       commit_valid,
  input  logic       commit_exc,
  input  logic [4:0] commit_code,
  input  logic       commit_badvaddr_en,
  input  logic       commit_eret,
  input  logic [7:0] interrupt_flag,
  input  logic       allow_interrupt,
  output kind_t      kind,
  output logic [4:0] code,
  output logic       badvaddr_en
);

  always_comb begin
    kind        = NONE;
    code        = EXC_INT;
    badvaddr_en = 1'b0;
    if (commit_valid) begin
      if (allow_interrupt && (|interrupt_flag)) begin
        kind = INT;
      end else if (commit_exc) begin
        kind        = EXC;
        code        = commit_code;
        badvaddr_en = commit_badvaddr_en;
      end else if (commit_eret) begin
        kind = ERET;
      end
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Commit-side exception sequencer: captures one event, drains memory traffic,
// then fires a single-cycle exception bundle to CP0 plus a fetch redirect.
module exception_unit
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic        commit_exc,
  input  logic [4:0]  commit_code,
  input  logic        commit_badvaddr_en,
  input  logic [31:0] commit_badvaddr,
  input  logic        commit_eret,
  input  logic [7:0]  interrupt_flag,
  input  logic        allow_interrupt,
  input  logic [31:0] epc_address,
  input  logic        mem_busy,
  output logic        exp_en,
  output logic        exp_badvaddr_en,
  output logic [31:0] exp_badvaddr,
  output logic        exp_bd,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic        exl_clean,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_t      state_reg, state_next;
  kind_t       kind_sel;
  logic [4:0]  code_sel;
  logic        badvaddr_en_sel;

  kind_t       kind_reg;
  logic [4:0]  code_reg;
  logic        badvaddr_en_reg;
  logic [31:0] badvaddr_reg;
  logic        bd_reg;
  logic [31:0] pc_reg;
  logic [31:0] epc_reg;

  logic        in_exl_reg;
  logic [4:0]  last_code_reg;
  logic        last_bd_reg;

  exc_priority u_priority (
    .commit_valid       (commit_valid),
    .commit_exc         (commit_exc),
    .commit_code        (commit_code),
    .commit_badvaddr_en (commit_badvaddr_en),
    .commit_eret        (commit_eret),
    .interrupt_flag     (interrupt_flag),
    .allow_interrupt    (allow_interrupt),
    .kind               (kind_sel),
    .code               (code_sel),
    .badvaddr_en        (badvaddr_en_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      kind_reg        <= NONE;
      code_reg        <= 5'd0;
      badvaddr_en_reg <= 1'b0;
      badvaddr_reg    <= 32'd0;
      bd_reg          <= 1'b0;
      pc_reg          <= 32'd0;
      epc_reg         <= 32'd0;
      in_exl_reg      <= 1'b0;
      last_code_reg   <= 5'd0;
      last_bd_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && kind_sel != NONE) begin
        kind_reg        <= kind_sel;
        code_reg        <= code_sel;
        badvaddr_en_reg <= badvaddr_en_sel;
        badvaddr_reg    <= commit_badvaddr;
        bd_reg          <= commit_bd;
        pc_reg          <= commit_pc;
        epc_reg         <= epc_address;
      end
      // Shadow of Status.EXL, updated in step with the CP0 write.
      if (state_reg == REDIRECT) begin
        if (kind_reg == ERET) begin
          in_exl_reg <= 1'b0;
        end else begin
          in_exl_reg <= 1'b1;
          if (!in_exl_reg) begin
            last_code_reg <= code_reg;
            last_bd_reg   <= bd_reg;
          end
        end
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    exp_en          = 1'b0;
    exp_badvaddr_en = 1'b0;
    exp_badvaddr    = 32'd0;
    exp_bd          = 1'b0;
    exp_code        = 5'd0;
    exp_epc         = 32'd0;
    exl_clean       = 1'b0;
    flush           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    case (state_reg)
      IDLE: begin
        if (kind_sel != NONE) state_next = DRAIN;
      end
      DRAIN: begin
        flush = 1'b1;
        stall = 1'b1;
        if (!mem_busy) state_next = REDIRECT;
      end
      REDIRECT: begin
        flush          = 1'b1;
        stall          = 1'b1;
        exp_en         = 1'b1;
        redirect_valid = 1'b1;
        state_next     = IDLE;
        if (kind_reg == ERET) begin
          // Cause is rewritten with the values of the exception being returned from.
          exl_clean   = 1'b1;
          exp_epc     = epc_reg;
          exp_code    = last_code_reg;
          exp_bd      = last_bd_reg;
          redirect_pc = epc_reg;
        end else begin
          exp_code        = code_reg;
          exp_badvaddr_en = badvaddr_en_reg;
          exp_badvaddr    = badvaddr_reg;
          redirect_pc     = EXC_VECTOR;
          if (in_exl_reg) begin
            exp_epc = epc_reg;
            exp_bd  = last_bd_reg;
          end else begin
            exp_epc = bd_reg ? (pc_reg - 32'd4) : pc_reg;
            exp_bd  = bd_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: directed scenarios plus randomized
// events compared against a rule-level model of the CP0 exception bundle.
module tb_exception_unit;
  import exc_pkg::*;

  logic        clk;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        commit_exc;
  logic [4:0]  commit_code;
  logic        commit_badvaddr_en;
  logic [31:0] commit_badvaddr;
  logic        commit_eret;
  logic [7:0]  interrupt_flag;
  logic        allow_interrupt;
  logic [31:0] epc_address;
  logic        mem_busy;
  logic        exp_en;
  logic        exp_badvaddr_en;
  logic [31:0] exp_badvaddr;
  logic        exp_bd;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exl_clean;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct packed {
    logic        bva_en;
    logic [31:0] bva;
    logic        bd;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        exl_clean;
    logic [31:0] rpc;
    logic        rv;
  } bundle_t;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: what CP0 holds as a result of delivered events.
  bit         m_in_exl = 0;
  logic [4:0] m_last_code = 5'd0;
  bit         m_last_bd = 0;

  wire [107:0] all_outs = {exp_en, exp_badvaddr_en, exp_badvaddr, exp_bd, exp_code, exp_epc,
                           exl_clean, flush, stall, redirect_valid, redirect_pc};

  exception_unit dut (
    .clk                (clk),
    .rst                (rst),
    .commit_valid       (commit_valid),
    .commit_pc          (commit_pc),
    .commit_bd          (commit_bd),
    .commit_exc         (commit_exc),
    .commit_code        (commit_code),
    .commit_badvaddr_en (commit_badvaddr_en),
    .commit_badvaddr    (commit_badvaddr),
    .commit_eret        (commit_eret),
    .interrupt_flag     (interrupt_flag),
    .allow_interrupt    (allow_interrupt),
    .epc_address        (epc_address),
    .mem_busy           (mem_busy),
    .exp_en             (exp_en),
    .exp_badvaddr_en    (exp_badvaddr_en),
    .exp_badvaddr       (exp_badvaddr),
    .exp_bd             (exp_bd),
    .exp_code           (exp_code),
    .exp_epc            (exp_epc),
    .exl_clean          (exl_clean),
    .flush              (flush),
    .stall              (stall),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_commit();
    commit_valid       = 1'b0;
    commit_pc          = 32'd0;
    commit_bd          = 1'b0;
    commit_exc         = 1'b0;
    commit_code        = 5'd0;
    commit_badvaddr_en = 1'b0;
    commit_badvaddr    = 32'd0;
    commit_eret        = 1'b0;
    interrupt_flag     = 8'd0;
    allow_interrupt    = 1'b0;
    epc_address        = 32'd0;
  endtask

  task automatic set_commit(input bit exc, input logic [4:0] code, input bit bva_en,
                            input logic [31:0] bva, input logic [31:0] pc, input bit bd,
                            input bit eret, input logic [7:0] iflag, input bit allow,
                            input logic [31:0] epc);
    commit_valid       = 1'b1;
    commit_exc         = exc;
    commit_code        = code;
    commit_badvaddr_en = bva_en;
    commit_badvaddr    = bva;
    commit_pc          = pc;
    commit_bd          = bd;
    commit_eret        = eret;
    interrupt_flag     = iflag;
    allow_interrupt    = allow;
    epc_address        = epc;
  endtask

  // Predicts the bundle for the commit inputs currently driven and updates CP0 model state.
  task automatic model_event(output bundle_t e, output bit ev);
    bit is_int, is_exc, is_eret;
    e       = '0;
    is_int  = commit_valid && allow_interrupt && (interrupt_flag != 8'd0);
    is_exc  = commit_valid && !is_int && commit_exc;
    is_eret = commit_valid && !is_int && !is_exc && commit_eret;
    ev      = is_int || is_exc || is_eret;
    if (is_eret) begin
      e.rv        = 1'b1;
      e.exl_clean = 1'b1;
      e.code      = m_last_code;
      e.bd        = m_last_bd;
      e.epc       = epc_address;
      e.rpc       = epc_address;
      m_in_exl    = 0;
    end else if (ev) begin
      e.rv     = 1'b1;
      e.code   = is_int ? 5'd0 : commit_code;
      e.bva_en = is_exc && commit_badvaddr_en;
      e.bva    = e.bva_en ? commit_badvaddr : 32'd0;
      e.rpc    = 32'hBFC0_0380;
      if (!m_in_exl) begin
        e.epc       = commit_bd ? commit_pc - 32'd4 : commit_pc;
        e.bd        = commit_bd;
        m_last_code = e.code;
        m_last_bd   = commit_bd;
      end else begin
        e.epc = epc_address;
        e.bd  = m_last_bd;
      end
      m_in_exl = 1;
    end
  endtask

  // Drives an already-presented event through DRAIN, holding mem_busy for 'busy' cycles.
  // Reports the bundle seen on exp_en, its latency and flush/stall behaviour.
  task automatic deliver(input int busy, input bit junk, output bundle_t got, output int lat,
                         output bit fs_ok, output bit post_ok, output bit to);
    got = '0; fs_ok = 1; post_ok = 1; to = 0;
    @(posedge clk); #1;
    lat = 1;
    clear_commit();
    if (junk) set_commit(1'b1, OV, 1'b1, 32'hDEAD_0001, 32'h8000_0F00, 1'b0, 1'b0,
                         8'h01, 1'b1, 32'h1234_5678);
    mem_busy = (lat <= busy);
    while (exp_en !== 1'b1 && lat < 40) begin
      if (!(flush === 1'b1 && stall === 1'b1)) fs_ok = 0;
      @(posedge clk); #1;
      lat++;
      clear_commit();
      mem_busy = (lat <= busy);
    end
    if (exp_en !== 1'b1) begin
      to = 1;
    end else begin
      if (!(flush === 1'b1 && stall === 1'b1)) fs_ok = 0;
      got.bva_en    = exp_badvaddr_en;
      got.bva       = exp_badvaddr_en ? exp_badvaddr : 32'd0;
      got.bd        = exp_bd;
      got.code      = exp_code;
      got.epc       = exp_epc;
      got.exl_clean = exl_clean;
      got.rpc       = redirect_pc;
      got.rv        = redirect_valid;
    end
    mem_busy = 1'b0;
    @(posedge clk); #1;
    if (exp_en !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0 || stall !== 1'b0)
      post_ok = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_commit(1'b1, SYS, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 8'hFF, 1'b1, 32'h5);
    mem_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (all_outs !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs cycle %0d got %h want 0", i, all_outs);
      end
    end
    clear_commit();
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (all_outs !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle got %h want 0", all_outs);
    end
    m_in_exl = 0; m_last_code = 5'd0; m_last_bd = 0;
    $display("[TB] reset: outputs checked during and after reset");
  endtask

  task automatic test_syscall();
    bundle_t e, got; bit ev, fs, post, to; int lat;
    set_commit(1'b1, SYS, 1'b0, 32'd0, 32'h8000_0100, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    model_event(e, ev);
    deliver(0, 0, got, lat, fs, post, to);
    tests_run++;
    if (to || got !== e) begin
      tests_failed++;
      $display("FAIL syscall_bundle got %h want %h timeout=%0d", got, e, to);
    end
    tests_run++;
    if (got.epc !== 32'h8000_0100 || got.code !== 5'd8 || got.rpc !== 32'hBFC0_0380 || got.bd !== 1'b0) begin
      tests_failed++;
      $display("FAIL syscall_fields epc=%h code=%0d rpc=%h bd=%0d want 80000100/8/bfc00380/0",
               got.epc, got.code, got.rpc, got.bd);
    end
    tests_run++;
    if (lat !== 2 || !fs || !post) begin
      tests_failed++;
      $display("FAIL syscall_timing lat=%0d fs_ok=%0d post_ok=%0d want lat=2 1 1", lat, fs, post);
    end
    $display("[TB] syscall: code=%0d epc=%h lat=%0d", got.code, got.epc, lat);
  endtask

  task automatic test_eret(input logic [31:0] epc, input string tag);
    bundle_t e, got; bit ev, fs, post, to; int lat;
    set_commit(1'b0, 5'd0, 1'b0, 32'd0, 32'h8000_0500, 1'b0, 1'b1, 8'h00, 1'b0, epc);
    model_event(e, ev);
    deliver(0, 0, got, lat, fs, post, to);
    tests_run++;
    if (to || got !== e || lat !== 2 || !fs || !post) begin
      tests_failed++;
      $display("FAIL eret_%s got %h want %h lat=%0d fs=%0d post=%0d", tag, got, e, lat, fs, post);
    end
    tests_run++;
    if (got.exl_clean !== 1'b1 || got.rpc !== epc || got.bva_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL eret_%s_fields exl_clean=%0d rpc=%h bva_en=%0d want 1 %h 0",
               tag, got.exl_clean, got.rpc, got.bva_en, epc);
    end
    $display("[TB] eret %s: code=%0d bd=%0d rpc=%h", tag, got.code, got.bd, got.rpc);
  endtask

  task automatic test_drain_adel();
    bundle_t e, got; bit ev, fs, post, to; int lat;
    set_commit(1'b1, ADEL, 1'b1, 32'h0000_0003, 32'h8000_0204, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0);
    model_event(e, ev);
    deliver(3, 0, got, lat, fs, post, to);
    tests_run++;
    if (to || got !== e) begin
      tests_failed++;
      $display("FAIL adel_bundle got %h want %h timeout=%0d", got, e, to);
    end
    tests_run++;
    if (got.epc !== 32'h8000_0200 || got.bd !== 1'b1 || got.bva_en !== 1'b1 || got.bva !== 32'h3) begin
      tests_failed++;
      $display("FAIL adel_fields epc=%h bd=%0d bva_en=%0d bva=%h want 80000200/1/1/3",
               got.epc, got.bd, got.bva_en, got.bva);
    end
    tests_run++;
    if (lat !== 5 || !fs || !post) begin
      tests_failed++;
      $display("FAIL adel_timing lat=%0d fs_ok=%0d post_ok=%0d want lat=5 1 1", lat, fs, post);
    end
    $display("[TB] adel: epc=%h lat=%0d", got.epc, lat);
  endtask

  task automatic test_nested();
    bundle_t e, got; bit ev, fs, post, to; int lat;
    set_commit(1'b1, OV, 1'b0, 32'd0, 32'h8000_0300, 1'b0, 1'b0, 8'h00, 1'b0, 32'h8000_0100);
    model_event(e, ev);
    deliver(1, 0, got, lat, fs, post, to);
    tests_run++;
    if (to || got !== e || lat !== 3) begin
      tests_failed++;
      $display("FAIL nested_bundle got %h want %h lat=%0d", got, e, lat);
    end
    tests_run++;
    if (got.epc !== 32'h8000_0100 || got.code !== 5'd12) begin
      tests_failed++;
      $display("FAIL nested_fields epc=%h code=%0d want 80000100/12", got.epc, got.code);
    end
    $display("[TB] nested: epc=%h code=%0d bd=%0d", got.epc, got.code, got.bd);
  endtask

  task automatic test_int_priority();
    bundle_t e, got; bit ev, fs, post, to; int lat;
    set_commit(1'b1, RI, 1'b1, 32'h0000_0044, 32'h8000_0400, 1'b0, 1'b0, 8'h04, 1'b1, 32'h0);
    model_event(e, ev);
    deliver(0, 1, got, lat, fs, post, to);
    tests_run++;
    if (to || got !== e) begin
      tests_failed++;
      $display("FAIL int_bundle got %h want %h timeout=%0d", got, e, to);
    end
    tests_run++;
    if (got.code !== 5'd0 || got.bva_en !== 1'b0 || got.epc !== 32'h8000_0400) begin
      tests_failed++;
      $display("FAIL int_fields code=%0d bva_en=%0d epc=%h want 0/0/80000400", got.code, got.bva_en, got.epc);
    end
    tests_run++;
    if (lat !== 2 || !fs || !post) begin
      tests_failed++;
      $display("FAIL int_timing lat=%0d fs_ok=%0d post_ok=%0d", lat, fs, post);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (flush !== 1'b0 || exp_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL int_junk_ignored flush=%0d exp_en=%0d want 0 0", flush, exp_en);
    end
    $display("[TB] interrupt: code=%0d epc=%h", got.code, got.epc);
  endtask

  task automatic test_wrap();
    bundle_t e, got; bit ev, fs, post, to; int lat;
    set_commit(1'b1, BP, 1'b0, 32'd0, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0);
    model_event(e, ev);
    deliver(0, 0, got, lat, fs, post, to);
    tests_run++;
    if (to || got !== e || got.epc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_epc got %h want %h (epc fffffffc)", got, e);
    end
    $display("[TB] wrap: epc=%h", got.epc);
  endtask

  task automatic test_reset_drain();
    int pulses;
    set_commit(1'b1, SYS, 1'b0, 32'd0, 32'h8000_0600, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    @(posedge clk); #1;
    clear_commit();
    mem_busy = 1'b1;
    tests_run++;
    if (flush !== 1'b1 || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstdrain_in_drain flush=%0d stall=%0d want 1 1", flush, stall);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_busy = 1'b0;
    m_in_exl = 0; m_last_code = 5'd0; m_last_bd = 0;
    tests_run++;
    if (all_outs !== '0) begin
      tests_failed++;
      $display("FAIL rstdrain_outputs got %h want 0", all_outs);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      mem_busy = 1'($urandom);
      @(posedge clk); #1;
      if (exp_en !== 1'b0 || flush !== 1'b0) pulses++;
    end
    mem_busy = 1'b0;
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL rstdrain_no_pulse got %0d active cycles want 0", pulses);
    end
    $display("[TB] reset in drain: active cycles after reset=%0d", pulses);
  endtask

  task automatic test_back_to_back();
    bundle_t e, got; bit ev, fs, post, to; int lat, busy;
    logic [4:0] code;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: code = ADEL;
        1: code = ADES;
        2: code = SYS;
        3: code = BP;
        4: code = RI;
        default: code = OV;
      endcase
      set_commit(1'($urandom), code, 1'($urandom), $urandom, $urandom, 1'($urandom),
                 1'($urandom), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                 1'($urandom), $urandom);
      commit_valid = ($urandom_range(0, 7) != 0);
      model_event(e, ev);
      if (!ev) begin
        @(posedge clk); #1;
        clear_commit();
        tests_run++;
        if (flush !== 1'b0 || exp_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_noevent n=%0d flush=%0d exp_en=%0d want 0 0", n, flush, exp_en);
        end
        $display("[TB] rand %0d: no event", n);
      end else begin
        busy = $urandom_range(0, 3);
        deliver(busy, 1'($urandom), got, lat, fs, post, to);
        tests_run++;
        if (to || got !== e || lat !== busy + 2 || !fs || !post) begin
          tests_failed++;
          $display("FAIL rand_event n=%0d got %h want %h lat=%0d want %0d fs=%0d post=%0d",
                   n, got, e, lat, busy + 2, fs, post);
        end
        $display("[TB] rand %0d: code=%0d epc=%h exl_clean=%0d lat=%0d", n, got.code, got.epc,
                 got.exl_clean, lat);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_busy = 1'b0;
    clear_commit();
    @(posedge clk); #1;
    test_reset();
    test_syscall();
    test_eret(32'h8000_0104, "after_syscall");
    test_drain_adel();
    test_nested();
    test_eret(32'h8000_0200, "after_nested");
    test_int_priority();
    test_eret(32'h8000_0400, "after_int");
    test_wrap();
    test_eret(32'h0000_0000, "after_wrap");
    test_reset_drain();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
